// File: rtl/cflow_pkg.sv
// Shared definitions for the CF-Log writer: log entry layout, default log size and FSM encoding.
package cflow_pkg;

   localparam logic [15:0] LOG_SIZE_DEFAULT = 16'h0080;

   typedef struct packed {
      logic [15:0] ptr;
      logic [15:0] src;
      logic [15:0] dest;
   } entry_t;

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_WR_SRC     = 2'd1;
   localparam logic [1:0] ST_WR_DEST    = 2'd2;
   localparam logic [1:0] ST_FLUSH_WAIT = 2'd3;

endpackage

// File: rtl/cflog_fifo.sv
// Small synchronous FIFO buffering log entries; a pop in the same cycle frees a slot for a push when full.
module cflog_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 48
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cflog_writer.sv
// Commits {ptr,src,dest} control-flow log entries as two 16-bit CF-Log words, draining
// the entry FIFO completely before handing a flush over to the TCB.
module cflog_writer
   import cflow_pkg::*;
#(
   parameter logic [15:0] LOG_SIZE   = LOG_SIZE_DEFAULT,
   parameter int          FIFO_DEPTH = 4,
   parameter int          AW         = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          log_wen,
   input  logic [15:0]   log_ptr,
   input  logic [15:0]   log_src,
   input  logic [15:0]   log_dest,
   input  logic          flush_req,
   input  logic          flush_done,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   output logic          flush_ready,
   output logic          overflow,
   output logic [15:0]   entries
);

   logic [1:0]  state;
   entry_t      in_entry;
   entry_t      head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;
   logic        drop;
   logic        pending;
   logic [15:0] cur_ptr;
   logic [15:0] cur_dest;
   logic [15:0] dest_addr;
   logic        unused_ptr_bits;

   assign in_entry        = '{ptr: log_ptr, src: log_src, dest: log_dest};
   assign pop             = !fifo_empty && (state == ST_IDLE || state == ST_WR_DEST);
   assign drop            = log_wen && fifo_full && !pop;
   assign dest_addr       = (cur_ptr + 16'd1) & (LOG_SIZE - 16'd1);
   assign unused_ptr_bits = ^{head.ptr[15:AW], dest_addr[15:AW]};

   cflog_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (log_wen),
      .pop   (pop),
      .wdata (in_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A pending flush is only honoured from IDLE with an empty FIFO, so every entry
   // accepted up to the request is already in memory when flush_ready rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         mem_wen     <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         flush_ready <= 1'b0;
         overflow    <= 1'b0;
         entries     <= '0;
         pending     <= 1'b0;
         cur_ptr     <= '0;
         cur_dest    <= '0;
      end else begin
         mem_wen <= 1'b0;
         if (state != ST_FLUSH_WAIT) pending <= pending | flush_req;
         case (state)
            ST_IDLE, ST_WR_DEST: begin
               if (state == ST_WR_DEST && entries != 16'hFFFF) entries <= entries + 16'd1;
               if (pop) begin
                  state     <= ST_WR_SRC;
                  mem_wen   <= 1'b1;
                  mem_addr  <= head.ptr[AW-1:0];
                  mem_wdata <= head.src;
                  cur_ptr   <= head.ptr;
                  cur_dest  <= head.dest;
               end else if (state == ST_IDLE && pending) begin
                  state       <= ST_FLUSH_WAIT;
                  flush_ready <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WR_SRC: begin
               state     <= ST_WR_DEST;
               mem_wen   <= 1'b1;
               mem_addr  <= dest_addr[AW-1:0];
               mem_wdata <= cur_dest;
            end
            default: begin
               if (flush_done) begin
                  state       <= ST_IDLE;
                  flush_ready <= 1'b0;
                  entries     <= '0;
                  overflow    <= 1'b0;
                  pending     <= flush_req;
               end
            end
         endcase
         if (drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cflog_writer.sv
// Self-checking bench for cflog_writer: latency vector table, flush/overflow/reset sequences
// and a randomized run scored against an in-order model of committed log words.
module tb_cflog_writer;

   localparam int LOG_WORDS = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        log_wen;
   logic [15:0] log_ptr;
   logic [15:0] log_src;
   logic [15:0] log_dest;
   logic        flush_req;
   logic        flush_done;
   logic        mem_wen;
   logic [6:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        flush_ready;
   logic        overflow;
   logic [15:0] entries;

   typedef struct {
      logic [15:0] ptr;
      logic [15:0] src;
      logic [15:0] dest;
      logic [15:0] exp_src_addr;
      logic [15:0] exp_dest_addr;
   } vec_t;

   vec_t        vecs [5];
   logic [31:0] obs_q [$];
   logic [31:0] exp_q [$];
   int          checks = 0;
   int          passed = 0;
   int          exp_entries = 0;

   always #5 clk = ~clk;

   cflog_writer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .log_wen     (log_wen),
      .log_ptr     (log_ptr),
      .log_src     (log_src),
      .log_dest    (log_dest),
      .flush_req   (flush_req),
      .flush_done  (flush_done),
      .mem_wen     (mem_wen),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .flush_ready (flush_ready),
      .overflow    (overflow),
      .entries     (entries)
   );

   // Record every memory write as {address, data}, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n === 1'b1 && mem_wen === 1'b1) obs_q.push_back({9'd0, mem_addr, mem_wdata});
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Model: a word index maps to address index mod log depth
   function automatic logic [31:0] wordOf(input int word, input logic [15:0] data);
      return {16'(word % LOG_WORDS), data};
   endfunction

   task automatic expectEntry(input logic [15:0] p, input logic [15:0] s, input logic [15:0] d);
      exp_q.push_back(wordOf(int'(p), s));
      exp_q.push_back(wordOf(int'(p) + 1, d));
   endtask

   task automatic applyStimulus(input logic [15:0] p, input logic [15:0] s, input logic [15:0] d);
      log_wen  = 1'b1;
      log_ptr  = p;
      log_src  = s;
      log_dest = d;
      tick();
      log_wen  = 1'b0;
   endtask

   task automatic pulseFlushReq();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
   endtask

   task automatic pulseFlushDone();
      flush_done = 1'b1;
      tick();
      flush_done = 1'b0;
   endtask

   task automatic waitFlushReady(input string name);
      int guard = 0;
      while (flush_ready !== 1'b1 && guard < 100) begin
         tick();
         guard++;
      end
      checkOutput(name, {31'd0, flush_ready}, 32'd1);
   endtask

   task automatic compareWrites(input string name);
      int guard = 0;
      while (obs_q.size() < exp_q.size() && guard < 400) begin
         tick();
         guard++;
      end
      repeat (4) tick();
      checkOutput({name, "_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         checkOutput(name, obs_q.pop_front(), exp_q.pop_front());
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [15:0] p;
      logic [15:0] s;
      logic [15:0] d;

      vecs[0] = '{16'h0010, 16'hE100, 16'hE200, 16'h0010, 16'h0011};
      vecs[1] = '{16'h007F, 16'h1234, 16'h5678, 16'h007F, 16'h0000};
      vecs[2] = '{16'h003E, 16'hAAAA, 16'h5555, 16'h003E, 16'h003F};
      vecs[3] = '{16'h1234, 16'h0F0F, 16'hF0F0, 16'h0034, 16'h0035};
      vecs[4] = '{16'hFFFF, 16'hBEEF, 16'hCAFE, 16'h007F, 16'h0000};

      rst_n      = 1'b0;
      log_wen    = 1'b0;
      log_ptr    = '0;
      log_src    = '0;
      log_dest   = '0;
      flush_req  = 1'b0;
      flush_done = 1'b0;
      #12;
      checkOutput("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
      checkOutput("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
      checkOutput("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      checkOutput("rst_flush_ready", {31'd0, flush_ready}, 32'd0);
      checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
      checkOutput("rst_entries", {16'd0, entries}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) tick();

      // Three entries then a flush request: all six words land before flush_ready
      applyStimulus(16'h0020, 16'hA001, 16'hB001);
      applyStimulus(16'h0022, 16'hA002, 16'hB002);
      applyStimulus(16'h0024, 16'hA003, 16'hB003);
      expectEntry(16'h0020, 16'hA001, 16'hB001);
      expectEntry(16'h0022, 16'hA002, 16'hB002);
      expectEntry(16'h0024, 16'hA003, 16'hB003);
      pulseFlushReq();
      waitFlushReady("flush_ready_rise");
      checkOutput("flush_all_written", obs_q.size(), 32'd6);
      checkOutput("flush_entries", {16'd0, entries}, 32'd3);
      compareWrites("flush_words");
      checkOutput("flush_ready_held", {31'd0, flush_ready}, 32'd1);

      // Entries pushed while waiting stay buffered; a repeated request is ignored
      applyStimulus(16'h0030, 16'hC001, 16'hD001);
      applyStimulus(16'h0032, 16'hC002, 16'hD002);
      pulseFlushReq();
      repeat (3) tick();
      checkOutput("no_write_in_flush_wait", obs_q.size(), 32'd0);
      pulseFlushDone();
      exp_entries = 0;
      checkOutput("done_entries_cleared", {16'd0, entries}, 32'd0);
      checkOutput("done_ready_cleared", {31'd0, flush_ready}, 32'd0);
      expectEntry(16'h0030, 16'hC001, 16'hD001);
      expectEntry(16'h0032, 16'hC002, 16'hD002);
      compareWrites("resume_words");
      exp_entries += 2;
      checkOutput("resume_entries", {16'd0, entries}, exp_entries);
      checkOutput("ignored_req_no_flush", {31'd0, flush_ready}, 32'd0);

      // flush_req together with flush_done re-arms a fresh flush
      pulseFlushReq();
      waitFlushReady("flush2_ready");
      flush_req  = 1'b1;
      flush_done = 1'b1;
      tick();
      flush_req  = 1'b0;
      flush_done = 1'b0;
      exp_entries = 0;
      checkOutput("both_ready_low", {31'd0, flush_ready}, 32'd0);
      checkOutput("both_entries", {16'd0, entries}, 32'd0);
      tick();
      checkOutput("both_relatched", {31'd0, flush_ready}, 32'd1);
      pulseFlushDone();
      checkOutput("both_exit", {31'd0, flush_ready}, 32'd0);

      // Fill the FIFO while stalled: fifth entry dropped, then push+pop when full
      pulseFlushReq();
      waitFlushReady("flush3_ready");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(16'(16'h0040 + 2 * i), 16'(16'h1100 + i), 16'(16'h2200 + i));
         if (i < 4) expectEntry(16'(16'h0040 + 2 * i), 16'(16'h1100 + i), 16'(16'h2200 + i));
         if (i == 3) checkOutput("ovf_not_yet", {31'd0, overflow}, 32'd0);
      end
      checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
      pulseFlushDone();
      exp_entries = 0;
      checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);
      applyStimulus(16'h0050, 16'h3300, 16'h4400);
      expectEntry(16'h0050, 16'h3300, 16'h4400);
      compareWrites("full_pushpop_words");
      exp_entries += 5;
      checkOutput("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
      checkOutput("full_pushpop_entries", {16'd0, entries}, exp_entries);

      // flush_done outside a flush has no effect
      pulseFlushDone();
      tick();
      checkOutput("stray_done", {16'd0, entries}, exp_entries);

      // Five back-to-back entries on a draining writer: none lost
      for (int i = 0; i < 5; i++) begin
         applyStimulus(16'(16'h0060 + i), 16'(16'h5500 + i), 16'(16'h6600 + i));
         expectEntry(16'(16'h0060 + i), 16'(16'h5500 + i), 16'(16'h6600 + i));
      end
      compareWrites("burst5_words");
      exp_entries += 5;
      checkOutput("burst5_ovf", {31'd0, overflow}, 32'd0);
      checkOutput("burst5_entries", {16'd0, entries}, exp_entries);

      // Latency and address wrap vectors on an idle writer
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].ptr, vecs[v].src, vecs[v].dest);
         checkOutput($sformatf("vec%0d_n1_wen", v), {31'd0, mem_wen}, 32'd0);
         tick();
         checkOutput($sformatf("vec%0d_src_wen", v), {31'd0, mem_wen}, 32'd1);
         checkOutput($sformatf("vec%0d_src_addr", v), {25'd0, mem_addr}, {16'd0, vecs[v].exp_src_addr});
         checkOutput($sformatf("vec%0d_src_data", v), {16'd0, mem_wdata}, {16'd0, vecs[v].src});
         tick();
         checkOutput($sformatf("vec%0d_dest_wen", v), {31'd0, mem_wen}, 32'd1);
         checkOutput($sformatf("vec%0d_dest_addr", v), {25'd0, mem_addr}, {16'd0, vecs[v].exp_dest_addr});
         checkOutput($sformatf("vec%0d_dest_data", v), {16'd0, mem_wdata}, {16'd0, vecs[v].dest});
         tick();
         exp_entries++;
         checkOutput($sformatf("vec%0d_idle_wen", v), {31'd0, mem_wen}, 32'd0);
         checkOutput($sformatf("vec%0d_entries", v), {16'd0, entries}, exp_entries);
         repeat (2) tick();
      end
      obs_q.delete();

      // Randomized entries, at most one every two cycles
      for (int i = 0; i < 40; i++) begin
         p = ($urandom_range(0, 5) == 0) ? (16'h007F | 16'($urandom & 32'hFF00)) : 16'($urandom);
         s = 16'($urandom);
         d = 16'($urandom);
         applyStimulus(p, s, d);
         expectEntry(p, s, d);
         exp_entries++;
         repeat ($urandom_range(1, 3)) tick();
      end
      compareWrites("random_words");
      checkOutput("random_ovf", {31'd0, overflow}, 32'd0);
      checkOutput("random_entries", {16'd0, entries}, exp_entries);

      // Asynchronous reset in the middle of a source-word write
      applyStimulus(16'h0070, 16'h7777, 16'h8888);
      tick();
      checkOutput("pre_reset_wen", {31'd0, mem_wen}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_entries = 0;
      checkOutput("async_rst_wen", {31'd0, mem_wen}, 32'd0);
      checkOutput("async_rst_addr", {25'd0, mem_addr}, 32'd0);
      checkOutput("async_rst_wdata", {16'd0, mem_wdata}, 32'd0);
      checkOutput("async_rst_entries", {16'd0, entries}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) tick();
      checkOutput("post_reset_no_write", obs_q.size(), 32'd0);
      applyStimulus(16'h0071, 16'h9999, 16'hAAAA);
      expectEntry(16'h0071, 16'h9999, 16'hAAAA);
      compareWrites("post_reset_words");
      checkOutput("post_reset_entries", {16'd0, entries}, 32'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
